// File: rtl/sync_mesh_switch.sv
// Single-clock 2D-mesh router with one input FIFO per port, XY routing, per-output
// round-robin arbitration and a registered output stage on every port.
module sync_mesh_switch #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned PORTS  = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned X_BITS = 2,
  parameter int unsigned Y_BITS = 2,
  parameter int unsigned X_POS  = 1,
  parameter int unsigned Y_POS  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gen_enable,
  input  logic [PORTS-1:0]       req_up_i,
  input  logic [PORTS*WIDTH-1:0] Data_up_i,
  output logic [PORTS-1:0]       ack_up_o,
  output logic [PORTS-1:0]       req_dw_o,
  output logic [PORTS*WIDTH-1:0] Data_dw_o,
  input  logic [PORTS-1:0]       ack_dw_i
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned PortW = $clog2(PORTS);

  localparam int PortLocal = 0;
  localparam int PortNorth = 1;
  localparam int PortEast  = 2;
  localparam int PortSouth = 3;
  localparam int PortWest  = 4;

  localparam logic [X_BITS-1:0] XPos = X_BITS'(X_POS);
  localparam logic [Y_BITS-1:0] YPos = Y_BITS'(Y_POS);

  logic [WIDTH-1:0] mem_q [PORTS][DEPTH];
  logic [PtrW-1:0]  rd_ptr_q [PORTS];
  logic [PtrW-1:0]  rd_ptr_d [PORTS];
  logic [PtrW-1:0]  wr_ptr_q [PORTS];
  logic [PtrW-1:0]  wr_ptr_d [PORTS];
  logic [CntW-1:0]  cnt_q [PORTS];
  logic [CntW-1:0]  cnt_d [PORTS];
  logic [PORTS-1:0] fresh_q, fresh_d;
  logic             ready_q;

  logic [WIDTH-1:0] out_data_q [PORTS];
  logic [WIDTH-1:0] out_data_d [PORTS];
  logic [PORTS-1:0] out_vld_q, out_vld_d;
  logic [PortW-1:0] rr_ptr_q [PORTS];
  logic [PortW-1:0] rr_ptr_d [PORTS];

  logic [WIDTH-1:0] head [PORTS];
  logic [PORTS-1:0] head_vld;
  logic [PORTS-1:0] route [PORTS];
  logic [PORTS-1:0] grant [PORTS];
  logic [PORTS-1:0] push, pop;

  // ready_q holds ack_up_o low for the first cycle after reset releases.
  always_comb begin
    for (int p = 0; p < int'(PORTS); p++) begin
      ack_up_o[p] = ready_q && (cnt_q[p] < CntW'(DEPTH));
    end
  end

  // A flit written into an empty FIFO becomes readable one cycle later.
  always_comb begin
    logic [X_BITS-1:0] dx;
    logic [Y_BITS-1:0] dy;
    for (int p = 0; p < int'(PORTS); p++) begin
      head[p]     = mem_q[p][rd_ptr_q[p]];
      head_vld[p] = (cnt_q[p] != '0) && !fresh_q[p];
      dx          = head[p][X_BITS-1:0];
      dy          = head[p][X_BITS+Y_BITS-1:X_BITS];
      route[p]    = '0;
      if (dx > XPos)      route[p][PortEast]  = 1'b1;
      else if (dx < XPos) route[p][PortWest]  = 1'b1;
      else if (dy > YPos) route[p][PortNorth] = 1'b1;
      else if (dy < YPos) route[p][PortSouth] = 1'b1;
      else                route[p][PortLocal] = 1'b1;
    end
  end

  // Each input routes to exactly one output, so an input is never granted twice.
  always_comb begin
    int   idx;
    logic found;
    pop = '0;
    idx = 0;
    for (int o = 0; o < int'(PORTS); o++) begin
      grant[o]    = '0;
      rr_ptr_d[o] = rr_ptr_q[o];
      found       = 1'b0;
      if (gen_enable && (!out_vld_q[o] || ack_dw_i[o])) begin
        for (int k = 1; k <= int'(PORTS); k++) begin
          idx = (int'(rr_ptr_q[o]) + k) % int'(PORTS);
          if (!found && head_vld[idx] && route[idx][o]) begin
            found         = 1'b1;
            grant[o][idx] = 1'b1;
            pop[idx]      = 1'b1;
            rr_ptr_d[o]   = PortW'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < int'(PORTS); o++) begin
      out_vld_d[o]  = out_vld_q[o] & ~ack_dw_i[o];
      out_data_d[o] = out_data_q[o];
      for (int p = 0; p < int'(PORTS); p++) begin
        if (grant[o][p]) begin
          out_vld_d[o]  = 1'b1;
          out_data_d[o] = head[p];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(PORTS); p++) begin
      push[p]     = req_up_i[p] && ack_up_o[p];
      cnt_d[p]    = cnt_q[p] + CntW'(push[p]) - CntW'(pop[p]);
      fresh_d[p]  = push[p] && (cnt_q[p] == CntW'(pop[p]));
      wr_ptr_d[p] = wr_ptr_q[p];
      rd_ptr_d[p] = rd_ptr_q[p];
      if (push[p]) begin
        wr_ptr_d[p] = (wr_ptr_q[p] == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q[p] + PtrW'(1);
      end
      if (pop[p]) begin
        rd_ptr_d[p] = (rd_ptr_q[p] == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q[p] + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(PORTS); p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= Data_up_i[p*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_q   <= 1'b0;
      fresh_q   <= '0;
      out_vld_q <= '0;
      for (int p = 0; p < int'(PORTS); p++) begin
        cnt_q[p]      <= '0;
        rd_ptr_q[p]   <= '0;
        wr_ptr_q[p]   <= '0;
        out_data_q[p] <= '0;
        rr_ptr_q[p]   <= PortW'(PORTS - 1);
      end
    end else begin
      ready_q   <= 1'b1;
      fresh_q   <= fresh_d;
      out_vld_q <= out_vld_d;
      for (int p = 0; p < int'(PORTS); p++) begin
        cnt_q[p]      <= cnt_d[p];
        rd_ptr_q[p]   <= rd_ptr_d[p];
        wr_ptr_q[p]   <= wr_ptr_d[p];
        out_data_q[p] <= out_data_d[p];
        rr_ptr_q[p]   <= rr_ptr_d[p];
      end
    end
  end

  always_comb begin
    Data_dw_o = '0;
    for (int o = 0; o < int'(PORTS); o++) begin
      Data_dw_o[o*WIDTH +: WIDTH] = out_data_q[o];
    end
    req_dw_o = out_vld_q;
  end

endmodule

// File: tb/tb_sync_mesh_switch.sv
// Directed bench for sync_mesh_switch at WIDTH=32, DEPTH=4, switch at (1,1).
module tb_sync_mesh_switch;

  localparam int W = 32;
  localparam int P = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           gen_enable = 1'b1;
  logic [P-1:0]   req_up_i = '0;
  logic [P*W-1:0] Data_up_i = '0;
  logic [P-1:0]   ack_up_o;
  logic [P-1:0]   req_dw_o;
  logic [P*W-1:0] Data_dw_o;
  logic [P-1:0]   ack_dw_i = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] inq [P][$];
  logic [W-1:0] outq [P][$];
  int           outc [P][$];
  logic [P-1:0] up_x;

  sync_mesh_switch #(
    .WIDTH (W),
    .PORTS (P),
    .DEPTH (4),
    .X_BITS(2),
    .Y_BITS(2),
    .X_POS (1),
    .Y_POS (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .gen_enable(gen_enable),
    .req_up_i  (req_up_i),
    .Data_up_i (Data_up_i),
    .ack_up_o  (ack_up_o),
    .req_dw_o  (req_dw_o),
    .Data_dw_o (Data_dw_o),
    .ack_dw_i  (ack_dw_i)
  );

  always #5 clk = ~clk;

  // Upstream driver from inq and downstream monitor into outq.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int o = 0; o < P; o++) begin
        if (reset && req_dw_o[o] && ack_dw_i[o]) begin
          outq[o].push_back(Data_dw_o[o*W +: W]);
          outc[o].push_back(cyc);
        end
      end
      up_x = req_up_i & ack_up_o & {P{reset}};
      @(posedge clk);
      cyc++;
      #1;
      for (int p = 0; p < P; p++) begin
        if (up_x[p]) void'(inq[p].pop_front());
        req_up_i[p] = (inq[p].size() != 0);
        Data_up_i[p*W +: W] = (inq[p].size() != 0) ? inq[p][0] : '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_out();
    for (int o = 0; o < P; o++) begin
      outq[o].delete();
      outc[o].delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_dw_o !== 5'b0) begin
      errors++; $display("FAIL reset_req: got %b want 00000", req_dw_o);
    end
    checks++;
    if (ack_up_o !== 5'b0) begin
      errors++; $display("FAIL reset_ack: got %b want 00000", ack_up_o);
    end
    checks++;
    if (Data_dw_o !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", Data_dw_o);
    end
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ack_up_o !== 5'b0) begin
      errors++; $display("FAIL release_ack_low: got %b want 00000", ack_up_o);
    end
    @(negedge clk);
    checks++;
    if (ack_up_o !== 5'b11111) begin
      errors++; $display("FAIL release_ack_high: got %b want 11111", ack_up_o);
    end
  endtask

  task automatic test_single();
    bit seen = 0;
    ack_dw_i = '0;
    clear_out();
    inq[0].push_back(32'h0000_0006);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (req_up_i[0] && ack_up_o[0]) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL single_accept: got no upstream transfer want one");
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (req_dw_o !== ((k == 3) ? 5'b00100 : 5'b00000)) begin
        errors++; $display("FAIL single_latency T+%0d: got %b", k - 1, req_dw_o);
      end
    end
    checks++;
    if (Data_dw_o[2*W +: W] !== 32'h6) begin
      errors++; $display("FAIL single_data: got %h want 00000006", Data_dw_o[2*W +: W]);
    end
    ack_dw_i[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_dw_o[2] !== 1'b0) begin
      errors++; $display("FAIL single_drop: got %b want 0", req_dw_o[2]);
    end
    checks++;
    if (outq[2].size() != 1) begin
      errors++; $display("FAIL single_count: got %0d want 1", outq[2].size());
    end
    ack_dw_i = '0;
  endtask

  task automatic test_simultaneous();
    ack_dw_i = 5'b00001;
    clear_out();
    inq[2].push_back(32'h0000_2005);
    inq[4].push_back(32'h0000_4005);
    for (int i = 0; i < 20 && outq[0].size() < 2; i++) @(negedge clk);
    checks++;
    if (outq[0].size() != 2) begin
      errors++; $display("FAIL simul_count: got %0d want 2", outq[0].size());
    end else begin
      checks++;
      if (outq[0][0] !== 32'h2005) begin
        errors++; $display("FAIL simul_first: got %h want 00002005", outq[0][0]);
      end
      checks++;
      if (outq[0][1] !== 32'h4005) begin
        errors++; $display("FAIL simul_second: got %h want 00004005", outq[0][1]);
      end
      checks++;
      if (outc[0][1] - outc[0][0] != 1) begin
        errors++; $display("FAIL simul_gap: got %0d want 1", outc[0][1] - outc[0][0]);
      end
    end
  endtask

  task automatic test_round_robin();
    int src [3] = '{1, 3, 4};
    logic [W-1:0] exp;
    ack_dw_i = 5'b00001;
    clear_out();
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 3; j++) inq[src[j]].push_back(W'((src[j] << 12) | (i << 8) | 5));
    end
    for (int i = 0; i < 80 && outq[0].size() < 15; i++) @(negedge clk);
    checks++;
    if (outq[0].size() != 15) begin
      errors++; $display("FAIL rr_count: got %0d want 15", outq[0].size());
    end else begin
      for (int k = 0; k < 15; k++) begin
        exp = W'((src[k % 3] << 12) | ((k / 3) << 8) | 5);
        checks++;
        if (outq[0][k] !== exp) begin
          errors++; $display("FAIL rr_order[%0d]: got %h want %h", k, outq[0][k], exp);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    ack_dw_i = '0;
    clear_out();
    for (int i = 0; i < 6; i++) inq[0].push_back(W'((i << 8) | 6));
    repeat (12) @(negedge clk);
    checks++;
    if (inq[0].size() != 1) begin
      errors++; $display("FAIL bp_accepted: got %0d pending want 1", inq[0].size());
    end
    checks++;
    if (ack_up_o[0] !== 1'b0) begin
      errors++; $display("FAIL bp_ack: got %b want 0", ack_up_o[0]);
    end
    checks++;
    if (req_dw_o[2] !== 1'b1 || Data_dw_o[2*W +: W] !== 32'h6) begin
      errors++; $display("FAIL bp_hold: got %b/%h want 1/00000006", req_dw_o[2],
                         Data_dw_o[2*W +: W]);
    end
    ack_dw_i[2] = 1'b1;
    for (int i = 0; i < 40 && outq[2].size() < 6; i++) @(negedge clk);
    checks++;
    if (outq[2].size() != 6) begin
      errors++; $display("FAIL bp_count: got %0d want 6", outq[2].size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (outq[2][k] !== W'((k << 8) | 6)) begin
          errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, outq[2][k],
                             W'((k << 8) | 6));
        end
      end
    end
  endtask

  task automatic test_gen_enable();
    logic [W-1:0] exp [3] = '{32'h109, 32'h209, 32'h309};
    gen_enable = 1'b0;
    ack_dw_i   = 5'b00010;
    clear_out();
    for (int i = 0; i < 3; i++) inq[3].push_back(exp[i]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (req_dw_o !== 5'b0) begin
        errors++; $display("FAIL gen_off[%0d]: got %b want 00000", i, req_dw_o);
      end
    end
    gen_enable = 1'b1;
    for (int i = 0; i < 20 && outq[1].size() < 3; i++) @(negedge clk);
    checks++;
    if (outq[1].size() != 3) begin
      errors++; $display("FAIL gen_count: got %0d want 3", outq[1].size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (outq[1][k] !== exp[k]) begin
          errors++; $display("FAIL gen_order[%0d]: got %h want %h", k, outq[1][k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    ack_dw_i = '0;
    clear_out();
    for (int i = 0; i < 3; i++) inq[0].push_back(W'((i << 8) | 32'h0000_0006));
    repeat (8) @(negedge clk);
    checks++;
    if (req_dw_o[2] !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got %b want 1", req_dw_o[2]);
    end
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_dw_o !== 5'b0 || ack_up_o !== 5'b0) begin
      errors++; $display("FAIL mid_reset: got req %b ack %b want 00000", req_dw_o, ack_up_o);
    end
    @(negedge clk);
    checks++;
    if (ack_up_o !== 5'b11111) begin
      errors++; $display("FAIL mid_release: got %b want 11111", ack_up_o);
    end
    ack_dw_i = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (req_dw_o !== 5'b0) begin
        errors++; $display("FAIL mid_stale[%0d]: got %b want 00000", i, req_dw_o);
      end
    end
    checks++;
    if (outq[2].size() != 0) begin
      errors++; $display("FAIL mid_emitted: got %0d want 0", outq[2].size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_gen_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
